// File: rtl/ahb_calc_pkg.sv
// rtl/ahb_calc_pkg.sv - opcodes, FSM encoding and iteration-count helper for the calc engine
package ahb_calc_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_REM = 3'b100;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Divide-by-zero and illegal opcodes resolve at accept, so they take the short path.
  function automatic int iter_count(input logic [2:0] op, input logic b_zero, input int data_w);
    if (op == OP_MUL) return data_w;
    if ((op == OP_DIV || op == OP_REM) && !b_zero) return data_w;
    return 1;
  endfunction

endpackage

// File: rtl/ahb_calc_iter_div.sv
// rtl/ahb_calc_iter_div.sv - restoring divider, one quotient bit per step, MSB first
module ahb_calc_iter_div #(
  parameter int DATA_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic              step_i,
  input  logic [DATA_W-1:0] dividend_i,
  input  logic [DATA_W-1:0] divisor_i,
  output logic [DATA_W-1:0] quotient_o,
  output logic [DATA_W-1:0] remainder_o
);

  logic [DATA_W:0]   rem_q;
  logic [DATA_W:0]   rem_d;
  logic [DATA_W-1:0] quo_q;
  logic [DATA_W-1:0] quo_d;
  logic [DATA_W+1:0] shifted;
  logic [DATA_W+1:0] ext_div;
  logic              fits;

  // The dividend shifts out of quo_q MSB-first while quotient bits shift in at the LSB.
  always_comb begin
    shifted = {rem_q, quo_q[DATA_W-1]};
    ext_div = {2'b00, divisor_i};
    fits    = (shifted >= ext_div);
    rem_d   = fits ? (DATA_W+1)'(shifted - ext_div) : shifted[DATA_W:0];
    quo_d   = {quo_q[DATA_W-2:0], fits};
  end

  // Outputs are the post-step values so the caller can capture them on the final step edge.
  assign quotient_o  = quo_d;
  assign remainder_o = rem_d[DATA_W-1:0];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rem_q <= '0;
      quo_q <= '0;
    end else if (load_i) begin
      rem_q <= '0;
      quo_q <= dividend_i;
    end else if (step_i) begin
      rem_q <= rem_d;
      quo_q <= quo_d;
    end
  end

endmodule

// File: rtl/ahb_slave_calc_seq.sv
// rtl/ahb_slave_calc_seq.sv - multi-cycle ADD/SUB/MUL/DIV/REM engine with start/busy/done handshake
module ahb_slave_calc_seq
  import ahb_calc_pkg::*;
#(
  parameter  int DATA_W = 16,
  localparam int RES_W  = 2 * DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic              start_i,
  input  logic [2:0]        opcode_i,
  input  logic [DATA_W-1:0] operate_a_i,
  input  logic [DATA_W-1:0] operate_b_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [RES_W-1:0]  operate_res_o
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        op_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] mplier;
  logic [RES_W-1:0]  mcand;
  logic [RES_W-1:0]  acc;
  logic [RES_W-1:0]  acc_nxt;
  logic [RES_W-1:0]  res_nxt;
  logic              err_nxt;
  logic              accept;
  logic              div_step;
  logic              is_divrem;
  logic              b_zero;
  logic [DATA_W-1:0] quo;
  logic [DATA_W-1:0] rem;

  assign accept    = (state == ST_IDLE) && enable_i && start_i;
  assign is_divrem = (op_q == OP_DIV) || (op_q == OP_REM);
  assign b_zero    = (b_q == '0);
  assign div_step  = (state == ST_CALC) && enable_i && is_divrem;
  assign busy_o    = (state == ST_CALC) || (state == ST_DONE);
  assign done_o    = (state == ST_DONE);

  ahb_calc_iter_div #(.DATA_W(DATA_W)) u_div (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .load_i      (accept),
    .step_i      (div_step),
    .dividend_i  (operate_a_i),
    .divisor_i   (b_q),
    .quotient_o  (quo),
    .remainder_o (rem)
  );

  assign acc_nxt = mplier[0] ? (acc + mcand) : acc;

  always_comb begin
    res_nxt = '0;
    err_nxt = 1'b0;
    case (op_q)
      OP_ADD: res_nxt = RES_W'(a_q) + RES_W'(b_q);
      OP_SUB: res_nxt = RES_W'(a_q) - RES_W'(b_q);
      OP_MUL: res_nxt = acc_nxt;
      OP_DIV: begin
        res_nxt = b_zero ? RES_W'({DATA_W{1'b1}}) : RES_W'(quo);
        err_nxt = b_zero;
      end
      OP_REM: begin
        res_nxt = b_zero ? RES_W'(a_q) : RES_W'(rem);
        err_nxt = b_zero;
      end
      default: err_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      op_q          <= '0;
      a_q           <= '0;
      b_q           <= '0;
      mcand         <= '0;
      mplier        <= '0;
      acc           <= '0;
      operate_res_o <= '0;
      err_o         <= 1'b0;
    end else if (!enable_i) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      operate_res_o <= '0;
      err_o         <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            state  <= ST_CALC;
            op_q   <= opcode_i;
            a_q    <= operate_a_i;
            b_q    <= operate_b_i;
            cnt    <= CNT_W'(iter_count(opcode_i, operate_b_i == '0, DATA_W));
            mcand  <= RES_W'(operate_a_i);
            mplier <= operate_b_i;
            acc    <= '0;
            err_o  <= 1'b0;
          end
        end
        ST_CALC: begin
          cnt    <= cnt - CNT_W'(1);
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          acc    <= acc_nxt;
          // Result and error are published only on the final iteration edge.
          if (cnt == CNT_W'(1)) begin
            state         <= ST_DONE;
            operate_res_o <= res_nxt;
            err_o         <= err_nxt;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_slave_calc_seq.sv
// tb/tb_ahb_slave_calc_seq.sv - scoreboard bench for ahb_slave_calc_seq at DATA_W 16, 8 and 32
module tb_ahb_slave_calc_seq;
  import ahb_calc_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic en  = 1'b1;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        s16 = 1'b0;
  logic [2:0]  o16 = '0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        busy16, done16, err16;
  logic [31:0] res16;

  logic        s8 = 1'b0;
  logic [2:0]  o8 = '0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8, err8;
  logic [15:0] res8;

  logic        s32 = 1'b0;
  logic [2:0]  o32 = '0;
  logic [31:0] a32 = '0, b32 = '0;
  logic        busy32, done32, err32;
  logic [63:0] res32;

  ahb_slave_calc_seq #(.DATA_W(16)) u16 (
    .clk_i(clk), .rst_i(rst), .enable_i(en), .start_i(s16), .opcode_i(o16),
    .operate_a_i(a16), .operate_b_i(b16), .busy_o(busy16), .done_o(done16),
    .err_o(err16), .operate_res_o(res16)
  );

  ahb_slave_calc_seq #(.DATA_W(8)) u8 (
    .clk_i(clk), .rst_i(rst), .enable_i(en), .start_i(s8), .opcode_i(o8),
    .operate_a_i(a8), .operate_b_i(b8), .busy_o(busy8), .done_o(done8),
    .err_o(err8), .operate_res_o(res8)
  );

  ahb_slave_calc_seq #(.DATA_W(32)) u32 (
    .clk_i(clk), .rst_i(rst), .enable_i(en), .start_i(s32), .opcode_i(o32),
    .operate_a_i(a32), .operate_b_i(b32), .busy_o(busy32), .done_o(done32),
    .err_o(err32), .operate_res_o(res32)
  );

  typedef struct {
    logic [63:0] res;
    logic        err;
    int          acc;
    int          lat;
    int          tag;
  } exp_t;

  typedef struct {
    int          cyc;
    bit          full;
    logic        busy;
    logic        done;
    logic        err;
    logic [63:0] res;
    int          tag;
  } probe_t;

  exp_t   q16[$];
  exp_t   q8[$];
  exp_t   q32[$];
  probe_t pq[$];
  int     n_checks = 0;
  int     n_errors = 0;
  bit     finish_req = 1'b0;

  task automatic score(input int w, input logic [63:0] got, input logic got_err);
    exp_t e;
    bit   have;
    have = 1'b0;
    n_checks++;
    case (w)
      8:       if (q8.size() > 0)  begin e = q8.pop_front();  have = 1'b1; end
      32:      if (q32.size() > 0) begin e = q32.pop_front(); have = 1'b1; end
      default: if (q16.size() > 0) begin e = q16.pop_front(); have = 1'b1; end
    endcase
    if (!have) begin
      n_errors++;
      $display("FAIL w%0d_unexpected_done res=%h err=%b required no done_o", w, got, got_err);
    end else if (got !== e.res || got_err !== e.err || (cyc - e.acc) != e.lat) begin
      n_errors++;
      $display("FAIL w%0d_op%0d res=%h err=%b lat=%0d required res=%h err=%b lat=%0d",
               w, e.tag, got, got_err, cyc - e.acc, e.res, e.err, e.lat);
    end
  endtask

  always @(negedge clk) begin : monitor
    probe_t p;
    if (done16 === 1'b1) score(16, {32'd0, res16}, err16);
    if (done8 === 1'b1)  score(8, {48'd0, res8}, err8);
    if (done32 === 1'b1) score(32, res32, err32);
    while (pq.size() > 0 && pq[0].cyc <= cyc) begin
      p = pq.pop_front();
      n_checks++;
      if (busy16 !== p.busy ||
          (p.full && (done16 !== p.done || err16 !== p.err || res16 !== p.res[31:0]))) begin
        n_errors++;
        $display("FAIL probe%0d busy=%b done=%b err=%b res=%h required busy=%b done=%b err=%b res=%h",
                 p.tag, busy16, done16, err16, res16, p.busy, p.done, p.err, p.res[31:0]);
      end
    end
    if (finish_req) begin
      n_checks++;
      if (q16.size() + q8.size() + q32.size() + pq.size() != 0) begin
        n_errors++;
        $display("FAIL pending_expectations count=%0d required 0",
                 q16.size() + q8.size() + q32.size() + pq.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d required finish before time limit", cyc);
    $fatal(1);
  end

  function automatic logic busy_of(input int w);
    case (w)
      8:       return busy8;
      32:      return busy32;
      default: return busy16;
    endcase
  endfunction

  task automatic drive(input int w, input logic s, input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    case (w)
      8:       begin s8 = s;  o8 = op;  a8 = a[7:0];   b8 = b[7:0];   end
      32:      begin s32 = s; o32 = op; a32 = a[31:0]; b32 = b[31:0]; end
      default: begin s16 = s; o16 = op; a16 = a[15:0]; b16 = b[15:0]; end
    endcase
  endtask

  task automatic probe(input bit full, input logic b, input logic d, input logic e, input logic [63:0] r, input int tag);
    probe_t p;
    p = '{cyc: cyc + 1, full: full, busy: b, done: d, err: e, res: r, tag: tag};
    pq.push_back(p);
  endtask

  task automatic push_exp(input int w, input exp_t e);
    case (w)
      8:       q8.push_back(e);
      32:      q32.push_back(e);
      default: q16.push_back(e);
    endcase
  endtask

  task automatic issue(input int w, input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] er, input logic ee, input int lat, input bit track, input int tag);
    exp_t e;
    int   n;
    n = 0;
    while (busy_of(w) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy_of(w)) begin
      e = '{res: '0, err: 1'b0, acc: 0, lat: 0, tag: -tag};
      push_exp(w, e);
    end
    drive(w, 1'b1, op, a, b);
    @(negedge clk);
    drive(w, 1'b0, op, a, b);
    e = '{res: er, err: ee, acc: cyc, lat: lat, tag: tag};
    if (track) push_exp(w, e);
  endtask

  task automatic model(input int w, input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                       output logic [63:0] r, output logic e, output int lat);
    logic [63:0] dmask;
    logic [63:0] rmask;
    dmask = (w == 32) ? 64'h0000_0000_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    rmask = (w == 32) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (2 * w)) - 64'd1);
    e   = 1'b0;
    lat = 1;
    r   = '0;
    case (op)
      OP_ADD: r = a + b;
      OP_SUB: r = (a - b) & rmask;
      OP_MUL: begin r = a * b; lat = w; end
      OP_DIV: if (b == 0) begin r = dmask; e = 1'b1; end else begin r = a / b; lat = w; end
      OP_REM: if (b == 0) begin r = a;     e = 1'b1; end else begin r = a % b; lat = w; end
      default: e = 1'b1;
    endcase
  endtask

  initial begin : stimulus
    logic [2:0]  op;
    logic [63:0] a, b, m, er;
    logic        ee;
    int          lat;
    int          w;

    repeat (2) @(negedge clk);
    probe(1'b1, 1'b0, 1'b0, 1'b0, 64'd0, 1);
    rst = 1'b0;
    @(negedge clk);

    issue(16, OP_ADD, 64'hFFFF, 64'h1, 64'h1_0000, 1'b0, 1, 1'b1, 2);
    issue(16, OP_SUB, 64'd3, 64'd5, 64'hFFFF_FFFE, 1'b0, 1, 1'b1, 3);

    issue(16, OP_MUL, 64'hFFFF, 64'hFFFF, 64'hFFFE_0001, 1'b0, 16, 1'b1, 4);
    probe(1'b0, 1'b1, 1'b0, 1'b0, 64'd0, 5);
    for (int i = 0; i < 3; i++) begin
      drive(16, 1'b1, OP_ADD, 64'(i), 64'(i + 7));
      @(negedge clk);
    end
    drive(16, 1'b0, OP_SUB, 64'h55, 64'hAA);

    issue(16, OP_DIV, 64'd100, 64'd7, 64'd14, 1'b0, 16, 1'b1, 6);
    issue(16, OP_REM, 64'd100, 64'd7, 64'd2, 1'b0, 16, 1'b1, 7);
    issue(16, OP_DIV, 64'h1234, 64'd0, 64'hFFFF, 1'b1, 1, 1'b1, 8);
    issue(16, OP_REM, 64'h1234, 64'd0, 64'h1234, 1'b1, 1, 1'b1, 9);

    // Abort a MUL by dropping enable on its fifth cycle.
    issue(16, OP_MUL, 64'h1234, 64'h5678, 64'd0, 1'b0, 16, 1'b0, 10);
    repeat (4) @(negedge clk);
    en = 1'b0;
    probe(1'b1, 1'b0, 1'b0, 1'b0, 64'd0, 10);
    @(negedge clk);
    en = 1'b1;
    repeat (20) @(negedge clk);
    issue(16, OP_ADD, 64'd2, 64'd2, 64'd4, 1'b0, 1, 1'b1, 11);

    // Reset in the middle of a DIV.
    issue(16, OP_DIV, 64'd100, 64'd7, 64'd0, 1'b0, 16, 1'b0, 12);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    probe(1'b1, 1'b0, 1'b0, 1'b0, 64'd0, 12);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    issue(16, 3'b111, 64'd9, 64'd9, 64'd0, 1'b1, 1, 1'b1, 13);
    issue(16, OP_MUL, 64'd3, 64'd5, 64'd15, 1'b0, 16, 1'b1, 14);
    probe(1'b1, 1'b1, 1'b0, 1'b0, 64'd0, 14);

    for (int k = 0; k < 2; k++) begin
      w = (k == 0) ? 8 : 32;
      m = (w == 32) ? 64'h0000_0000_FFFF_FFFF : ((64'd1 << w) - 64'd1);
      for (int i = 0; i < 20; i++) begin
        op = 3'($urandom_range(0, 7));
        a  = {$urandom, $urandom} & m;
        b  = {$urandom, $urandom} & m;
        if ($urandom_range(0, 4) == 0) b = '0;
        model(w, op, a, b, er, ee, lat);
        issue(w, op, a, b, er, ee, lat, 1'b1, 100 * w + i);
      end
    end

    repeat (40) @(negedge clk);
    finish_req = 1'b1;
  end

endmodule

// File: doc/ahb_slave_calc_seq.md
Name: ahb_slave_calc_seq

Overview:
Parametrised multi-cycle arithmetic engine that sits behind the AHB demo slave's register file. Supports ADD, SUB, MUL, DIV and REM on DATA_W-bit unsigned operands, with a start/busy/done handshake.
- ADD and SUB complete in one iteration. MUL uses an iterative shift-add datapath; DIV and REM use an iterative restoring divider.
- Operands are latched at start, and the result is held until the next operation.
- Illegal opcodes and divide-by-zero are reported on err_o.

Parameters:
- DATA_W, 16, operand width in bits; legal range 2..32.
- RES_W, 2*DATA_W, result width; derived, must not be overridden.

Ports:
- clk_i  input  1  clock; all state changes on the rising edge.
- rst_i  input  1  synchronous, active-high reset.
- enable_i  input  1  block enable; low forces IDLE and aborts any operation.
- start_i  input  1  request a new operation; sampled only in IDLE.
- opcode_i  input  3  000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 REM, 101-111 illegal.
- operate_a_i  input  DATA_W  operand A (dividend).
- operate_b_i  input  DATA_W  operand B (divisor).
- busy_o  output  1  high in CALC and DONE.
- done_o  output  1  one-cycle pulse when res_o/err_o become valid.
- err_o  output  1  illegal opcode or divide-by-zero; valid with done_o, held until the next accept.
- operate_res_o  output  RES_W  result; held until the next accept, abort or reset.

Behaviour:
- Reset (rst_i=1 at an edge): state IDLE; busy_o=0, done_o=0, err_o=0, operate_res_o=0; counter and operand registers cleared. rst_i has priority over enable_i and start_i, including mid-operation.
- enable_i=0 at an edge (no reset): state IDLE, operate_res_o=0, done_o=0, err_o=0. Any in-flight operation is dropped and produces no done_o.
- FSM states and transitions:
  - IDLE -> CALC: at an edge with enable_i=1 and start_i=1 (the accept edge). Latch opcode and operands, clear err_o, load ITER.
  - CALC -> DONE: after ITER edges in CALC.
  - DONE -> IDLE: always, after one cycle. done_o=1 only in DONE.
- Latency: done_o is high in the cycle following the ITER-th edge after the accept edge.
  - ITER=1 for ADD, SUB, illegal opcode and divide-by-zero.
  - ITER=DATA_W for MUL, DIV and REM.
- start_i while busy_o=1 is ignored. Operand and opcode changes while busy_o=1 are ignored.
- Back-to-back operation: a new start is accepted in the cycle after DONE, at the earliest.
- Arithmetic (unsigned; results zero-extended to RES_W):
  - ADD: a+b, with carry in bit DATA_W.
  - SUB: (a-b) mod 2^RES_W.
  - MUL: full 2*DATA_W-bit product.
  - DIV: quotient. REM: remainder.
- Divide-by-zero (b=0 on DIV or REM, detected at accept): DIV gives quotient {DATA_W{1}}, REM gives a; err_o=1.
- Illegal opcode: operate_res_o=0, err_o=1.
- MUL iteration: one multiplier bit per cycle, LSB first, shift-add into a 2*DATA_W accumulator.
- DIV/REM iteration: restoring division, one quotient bit per cycle, MSB first; remainder register is DATA_W+1 bits.
- Iteration counter width: clog2(DATA_W+1). No wrap occurs, because the counter stops at ITER.
- operate_res_o updates only at the CALC->DONE edge, or on clear. Intermediate values are never visible.

Decomposition:
- Package ahb_calc_pkg holds:
  - opcode localparams OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_REM;
  - state encoding ST_IDLE, ST_CALC, ST_DONE;
  - helper function for iteration count.
- One sub-module, ahb_calc_iter_div: the restoring divider datapath, taking DATA_W and exposing load/step/quotient/remainder.
- MUL, ADD and SUB stay in the top-level module.

Test Plan:
1. Reset: rst_i=1 for 2 cycles, then also mid-DIV -> next cycle busy_o=0, done_o=0, err_o=0, operate_res_o=0; no done_o afterwards.
2. ADD 0xFFFF+0x0001 -> done_o 1 cycle after accept, res=0x0001_0000, err_o=0. SUB 3-5 -> res=0xFFFF_FFFE.
3. MUL 0xFFFF*0xFFFF -> done_o exactly 16 cycles after accept, res=0xFFFE_0001. start_i pulsed and operands changed mid-op are ignored; exactly one done_o.
4. DIV 100/7 -> res=14; REM 100/7 -> res=2, both at 16-cycle latency. DIV 0x1234/0 -> res=0x0000_FFFF, err_o=1, latency 1. REM 0x1234/0 -> res=0x1234, err_o=1.
5. enable_i dropped on cycle 5 of MUL -> IDLE next cycle, res=0, no done_o. Re-enable and start ADD 2+2 -> res=4.
6. Illegal opcode 3'b111 -> res=0, err_o=1. Start issued on the cycle right after DONE is accepted. err_o clears on accept; random compare against a reference model for DATA_W=8 and DATA_W=32.
